// File: rtl/input_buf.sv
// Load-side input peripheral: synchronized switches, debounced push-buttons,
// sticky press flags and a 16-bit press-event counter on the CPU load/store bus.
module input_buf #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        wren,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] i_buf_data,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_data
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [31:0]      sw_s1_q, sw_s1_d;
  logic [31:0]      sw_q, sw_d;
  logic [3:0]       bt_s1_q, bt_s1_d;
  logic [3:0]       bt_s2_q, bt_s2_d;
  logic [3:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       flag_q, flag_d;
  logic [15:0]      evcnt_q, evcnt_d;

  logic [3:0]  sel;
  logic [3:0]  press;
  logic [2:0]  press_cnt;
  logic [3:0]  clr_mask;
  logic [31:0] raw;
  logic        unused_bits;

  assign sel         = addr[15:12];
  assign unused_bits = ^{addr[31:16], addr[11:0], i_buf_data[31:4]};

  always_comb begin
    sw_s1_d  = i_io_sw;
    sw_d     = sw_s1_q;
    bt_s1_d  = ~i_io_btn;
    bt_s2_d  = bt_s1_q;
    stable_d = stable_q;
    // The counter only runs while the synchronized button disagrees with stable.
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bt_s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = bt_s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    press     = stable_d & ~stable_q;
    press_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      press_cnt = press_cnt + 3'(press[i]);
    end

    // A press in the same cycle as a clear always survives.
    clr_mask = (wren && sel == 4'h2) ? i_buf_data[3:0] : 4'h0;
    flag_d   = (flag_q & ~clr_mask) | press;
    evcnt_d  = ((wren && sel == 4'h3) ? 16'h0000 : evcnt_q) + {13'b0, press_cnt};
  end

  always_comb begin
    case (sel)
      4'h0:    raw = sw_q;
      4'h1:    raw = {28'b0, stable_q};
      4'h2:    raw = {28'b0, flag_q};
      4'h3:    raw = {16'b0, evcnt_q};
      default: raw = 32'h0;
    endcase

    o_data = 32'h0;
    if (!wren) begin
      case (func3)
        3'b000:  o_data = {{24{raw[7]}}, raw[7:0]};
        3'b001:  o_data = {{16{raw[15]}}, raw[15:0]};
        3'b010:  o_data = raw;
        3'b100:  o_data = {24'b0, raw[7:0]};
        3'b101:  o_data = {16'b0, raw[15:0]};
        default: o_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1_q  <= '0;
      sw_q     <= '0;
      bt_s1_q  <= '0;
      bt_s2_q  <= '0;
      stable_q <= '0;
      flag_q   <= '0;
      evcnt_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_q     <= sw_d;
      bt_s1_q  <= bt_s1_d;
      bt_s2_q  <= bt_s2_d;
      stable_q <= stable_d;
      flag_q   <= flag_d;
      evcnt_q  <= evcnt_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_input_buf.sv
// Self-checking bench for input_buf: directed vector tables and corner-case
// sequences, then randomized traffic against a window-based reference model.
module tb_input_buf;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wren;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sw;
  logic [3:0]  btn_raw;
  logic [31:0] o_data;

  input_buf #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .wren       (wren),
    .func3      (func3),
    .addr       (addr),
    .i_buf_data (wdata),
    .i_io_sw    (sw),
    .i_io_btn   (btn_raw),
    .o_data     (o_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: switch/button synchronizer pipes, the last DB debouncer
  // inputs, and the architectural registers.
  logic [31:0] m_sw1, m_sw2;
  logic [3:0]  m_bp1, m_bp2;
  logic [3:0]  m_win [DB];
  logic [3:0]  m_stable, m_flag;
  logic [15:0] m_evcnt;

  typedef struct {
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] exp;
  } vec_t;

  vec_t sw_tbl [7];
  vec_t rst_tbl [4];

  task automatic modelReset();
    m_sw1 = '0; m_sw2 = '0; m_bp1 = '0; m_bp2 = '0;
    m_stable = '0; m_flag = '0; m_evcnt = '0;
    for (int k = 0; k < DB; k++) m_win[k] = '0;
  endtask

  // Stable flips once the last DB synchronized samples all disagree with it.
  task automatic modelStep();
    logic [3:0] in_now, nxt, prs, clr;
    bit all_diff;
    in_now = m_bp2;
    m_bp2  = m_bp1;
    m_bp1  = ~btn_raw;
    m_sw2  = m_sw1;
    m_sw1  = sw;
    for (int k = DB - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = in_now;
    nxt = m_stable;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++)
        if (m_win[k][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) nxt[i] = ~m_stable[i];
    end
    prs = nxt & ~m_stable;
    clr = (wren && addr[15:12] == 4'h2) ? wdata[3:0] : 4'h0;
    m_flag = (m_flag & ~clr) | prs;
    if (wren && addr[15:12] == 4'h3) m_evcnt = 16'h0;
    m_evcnt = m_evcnt + 16'($countones(prs));
    m_stable = nxt;
  endtask

  function automatic logic [31:0] expLoad(input logic [31:0] a, input logic [2:0] f3,
                                          input logic we);
    logic [31:0] r;
    if (we) return 32'h0;
    case (a[15:12])
      4'h0:    r = m_sw2;
      4'h1:    r = {28'h0, m_stable};
      4'h2:    r = {28'h0, m_flag};
      4'h3:    r = {16'h0, m_evcnt};
      default: r = 32'h0;
    endcase
    case (f3)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b010:  return r;
      3'b100:  return {24'h0, r[7:0]};
      3'b101:  return {16'h0, r[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelStep();
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic readReg(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] r);
    wren  = 1'b0;
    addr  = a;
    func3 = f3;
    #1;
    r = o_data;
  endtask

  task automatic checkReg(input string name, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] exp);
    logic [31:0] r;
    readReg(a, f3, r);
    checkOutput(name, r, exp);
  endtask

  task automatic storeReg(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    wren  = 1'b1;
    addr  = a;
    func3 = f3;
    wdata = d;
    #1;
    checkOutput("store_cycle_rdata", o_data, 32'h0);
    tick();
    wren = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] pressed, input logic [31:0] swv);
    btn_raw = ~pressed;
    sw      = swv;
  endtask

  initial begin
    logic [31:0] r, a;
    logic [3:0]  nb;

    sw_tbl[0] = '{32'h0000_0000, 3'b010, 32'h0000_80F0};
    sw_tbl[1] = '{32'h0000_0000, 3'b000, 32'hFFFF_FFF0};
    sw_tbl[2] = '{32'h0000_0000, 3'b100, 32'h0000_00F0};
    sw_tbl[3] = '{32'h0000_0000, 3'b001, 32'hFFFF_80F0};
    sw_tbl[4] = '{32'h0000_0000, 3'b101, 32'h0000_80F0};
    sw_tbl[5] = '{32'h0000_0000, 3'b011, 32'h0000_0000};
    sw_tbl[6] = '{32'h0000_0003, 3'b100, 32'h0000_00F0};
    for (int i = 0; i < 4; i++) rst_tbl[i] = '{32'(i) << 12, 3'b010, 32'h0};

    rst_n = 1'b0; wren = 1'b0; func3 = 3'b010; addr = '0; wdata = '0;
    applyStimulus(4'h0, 32'h0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) checkReg("reset_read", rst_tbl[i].a, rst_tbl[i].f3, rst_tbl[i].exp);
    rst_n = 1'b1;

    // Switch path: two-edge latency, then sign/size extension table.
    applyStimulus(4'h0, 32'h0000_80F0);
    waitCycles(2);
    for (int i = 0; i < 7; i++) checkReg("sw_vec", sw_tbl[i].a, sw_tbl[i].f3, sw_tbl[i].exp);
    applyStimulus(4'h0, 32'h0000_1234);
    tick();
    checkReg("sw_latency_1", 32'h0, 3'b010, 32'h0000_80F0);
    tick();
    checkReg("sw_latency_2", 32'h0, 3'b010, 32'h0000_1234);

    // Short glitch never reaches stable.
    applyStimulus(4'b0010, sw);
    waitCycles(3);
    applyStimulus(4'b0000, sw);
    waitCycles(8);
    checkReg("glitch_btn", 32'h1000, 3'b010, 32'h0);
    checkReg("glitch_flag", 32'h2000, 3'b010, 32'h0);
    checkReg("glitch_evcnt", 32'h3000, 3'b010, 32'h0);

    // Clean press: visible exactly 2+DB edges after the fall.
    applyStimulus(4'b0010, sw);
    for (int n = 1; n <= 6; n++) begin
      tick();
      checkReg("press_latency_btn", 32'h1000, 3'b010, (n == 6) ? 32'h2 : 32'h0);
    end
    checkReg("press_flag", 32'h2000, 3'b010, 32'h2);
    checkReg("press_evcnt", 32'h3000, 3'b010, 32'h1);
    waitCycles(4);
    applyStimulus(4'b0000, sw);
    for (int n = 1; n <= 6; n++) begin
      tick();
      checkReg("release_latency_btn", 32'h1000, 3'b010, (n == 6) ? 32'h0 : 32'h2);
    end
    checkReg("release_flag_sticky", 32'h2000, 3'b010, 32'h2);
    checkReg("release_evcnt", 32'h3000, 3'b010, 32'h1);

    // Write-one-to-clear on FLAG.
    applyStimulus(4'b1011, sw);
    waitCycles(6);
    applyStimulus(4'b0000, sw);
    waitCycles(6);
    checkReg("w1c_flag_pre", 32'h2000, 3'b010, 32'hB);
    checkReg("w1c_evcnt", 32'h3000, 3'b010, 32'h4);
    storeReg(32'h2000, 3'b010, 32'h9);
    checkReg("w1c_mask9", 32'h2000, 3'b010, 32'h2);
    storeReg(32'h2000, 3'b010, 32'h0);
    checkReg("w1c_mask0", 32'h2000, 3'b010, 32'h2);
    storeReg(32'h2000, 3'b000, 32'h2);
    checkReg("w1c_sb", 32'h2000, 3'b010, 32'h0);

    // Clear of flag[0] in the cycle stable[0] rises: the set wins.
    applyStimulus(4'b0001, sw);
    waitCycles(5);
    storeReg(32'h2000, 3'b010, 32'h1);
    checkReg("simul_flag", 32'h2000, 3'b010, 32'h1);
    checkReg("simul_btn", 32'h1000, 3'b010, 32'h1);
    checkReg("simul_evcnt_pre", 32'h3000, 3'b010, 32'h5);
    applyStimulus(4'b0000, sw);
    waitCycles(6);
    applyStimulus(4'b0100, sw);
    waitCycles(5);
    storeReg(32'h3000, 3'b010, 32'h0);
    checkReg("simul_evcnt", 32'h3000, 3'b010, 32'h1);
    applyStimulus(4'b0000, sw);
    waitCycles(6);

    // Counter wrap from 0xFFFF, then a double press.
    force dut.evcnt_q = 16'hFFFF;
    #1;
    release dut.evcnt_q;
    m_evcnt = 16'hFFFF;
    checkReg("evcnt_lhu", 32'h3000, 3'b101, 32'h0000_FFFF);
    checkReg("evcnt_lh", 32'h3000, 3'b001, 32'hFFFF_FFFF);
    applyStimulus(4'b1000, sw);
    waitCycles(6);
    checkReg("evcnt_wrap", 32'h3000, 3'b010, 32'h0);
    applyStimulus(4'b0000, sw);
    waitCycles(6);
    applyStimulus(4'b0101, sw);
    waitCycles(6);
    checkReg("evcnt_double", 32'h3000, 3'b010, 32'h2);
    applyStimulus(4'b0000, sw);
    waitCycles(6);

    // Asynchronous reset with a button held; debounce restarts afterwards.
    applyStimulus(4'b0100, 32'hDEAD_BEEF);
    waitCycles(6);
    checkReg("held_btn", 32'h1000, 3'b010, 32'h4);
    rst_n = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) checkReg("in_reset_read", rst_tbl[i].a, rst_tbl[i].f3, rst_tbl[i].exp);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      checkReg("post_reset_btn", 32'h1000, 3'b010, (n == 6) ? 32'h4 : 32'h0);
    end
    checkReg("post_reset_evcnt", 32'h3000, 3'b010, 32'h1);
    applyStimulus(4'b0000, sw);
    waitCycles(6);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      nb = btn_raw;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) nb[i] = ~nb[i];
      btn_raw = nb;
      sw = $urandom;
      a = $urandom;
      a[15:12] = 4'($urandom_range(0, 5));
      addr  = a;
      func3 = 3'($urandom_range(0, 7));
      wdata = $urandom;
      wren  = ($urandom_range(0, 3) == 0);
      #1;
      checkOutput("rand_load", o_data, expLoad(addr, func3, wren));
      tick();
    end
    wren = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_buf.md
# input_buf

Memory-mapped input peripheral block: the load-side counterpart of the LED/HEX/LCD output buffer on the same CPU load/store bus. Synchronizes the board switches, synchronizes and debounces the push-buttons, and keeps sticky press flags plus a press-event counter. The CPU reads all of these with LB/LBU/LH/LHU/LW, selected by addr[15:12]. Press flags and counter are cleared by stores.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive cycles a button must differ from its stable value before the stable value changes (bench uses 4); legal range ≥ 1
- i_clk  in  1  single clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- wren  in  1  1 = store cycle, 0 = load/read cycle
- func3  in  3  load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address; addr[15:12] selects the register
- i_buf_data  in  32  store data (write-one-to-clear mask)
- i_io_sw  in  32  raw switches, asynchronous, active-high
- i_io_btn  in  4  raw push-buttons, asynchronous, active-low (0 = pressed)
- o_data  out  32  load data to CPU, combinational

## Operation
- Input conditioning: btn_n = ~i_io_btn, so 1 = pressed. Both sw and btn_n pass through a 2-flop synchronizer (sw_s1/sw_s2, bt_s1/bt_s2).
- Switches: sw_q = sw_s2. No debounce.
- Debounce, per button i: cnt[i] is wide enough to hold DEBOUNCE_CYCLES.
  - If bt_s2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= bt_s2[i], cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Press event: press[i] = stable[i] goes 0→1 this cycle, i.e. the registered update. Release edges produce no event.
- Register map (addr[15:12]):
  - 0x0 SW: sw_q, read-only.
  - 0x1 BTN: {28'b0, stable}, read-only.
  - 0x2 FLAG: {28'b0, flag}, sticky. Set by press[i]; a store clears flag[i] where i_buf_data[i]=1, for any store func3.
  - 0x3 EVCNT: {16'b0, evcnt}. 16-bit count of press events; adds popcount(press) per cycle, wraps modulo 2^16. Any store to 0x3 clears it to 0.
  - Other addresses: read 0, stores ignored. Stores to 0x0/0x1 ignored.
- Simultaneous events:
  - Set and clear of the same flag bit in one cycle: set wins (flag = 1).
  - Store-clear of EVCNT and a press in one cycle: evcnt <= popcount(press).
- Read path when wren=0: raw = selected register.
  - LB: sign-extend raw[7:0]. LBU: zero-extend raw[7:0].
  - LH: sign-extend raw[15:0]. LHU: zero-extend raw[15:0].
  - LW: raw.
  - Other func3: 0.
- When wren=1: o_data = 0.
- Sub-word address bits addr[1:0] are ignored; lanes always come from bit 0.

## Timing
- Reset (async assert, sync to clock on deassert externally): all synchronizer flops, sw_q, stable, cnt, flag and evcnt go to 0, so o_data reads 0 for every register.
- Reset mid-debounce discards the count. Flags and the counter are lost.
- Switch latency: i_io_sw change is visible in SW reads after 2 rising edges.
- Button latency: a clean press is visible in BTN, FLAG and EVCNT 2 + DEBOUNCE_CYCLES edges after the raw change. Release has the same latency in BTN.
- Stores take effect at the rising edge of the store cycle. A load in the next cycle sees the cleared value.
- o_data is combinational from addr/func3/wren and registers: zero-cycle read latency, no handshake.

## Test plan
- Reset/read defaults: assert i_rst_n=0 mid-run with a button held → LW at 0x0000–0x3000 all return 0x00000000 while in reset. BTN reads 0x0 until the debounce completes after release of reset.
- Switch sign/size: i_io_sw=0x0000_80F0, wait 2 cycles → LW 0x0000 = 0x000080F0, LB = 0xFFFFFFF0, LBU = 0x000000F0, LH = 0xFFFF80F0, LHU = 0x000080F0. func3=011 → 0.
- Debounce (DEBOUNCE_CYCLES=4):
  - Pulse i_io_btn[1] low for 3 cycles → BTN stays 0x0, FLAG 0x0, EVCNT 0.
  - Hold low for 10 cycles → BTN = 0x2 exactly 6 edges after the fall, FLAG = 0x2, EVCNT = 1.
  - Release → BTN = 0x0, FLAG stays 0x2.
- W1C: FLAG = 0xB, SW 0x2000 with data 0x9 → FLAG = 0x2. Store data 0x0 → unchanged. SB with data 0x2 → 0x0.
- Simultaneous: issue the clear-store to 0x2000 (data 0x1) in the exact cycle stable[0] rises → FLAG[0] = 1. Store to 0x3000 in the same cycle as a press → EVCNT = 1.
- Counter wrap: preload via 65535 presses (or force evcnt=0xFFFF) then one press → EVCNT = 0x0000. Two buttons debounced in the same cycle → EVCNT increments by 2.
